// File: rtl/game_round_scheduler_if.sv
// Signal bundle between the round scheduler, the player keypad, start button
// and the point-matrix display controller.
interface game_round_scheduler_if;
  logic       start;
  logic       key_valid;
  logic [3:0] key_pos;
  logic       finish_boom;
  logic       disp_en;
  logic [3:0] disp_pos;
  logic [1:0] disp_color;
  logic       show_boom;
  logic [7:0] score;
  logic [7:0] miss;
  logic [7:0] round;
  logic       game_over;

  modport master (
    input  start, key_valid, key_pos, finish_boom,
    output disp_en, disp_pos, disp_color, show_boom, score, miss, round, game_over
  );

  modport slave (
    output start, key_valid, key_pos, finish_boom,
    input  disp_en, disp_pos, disp_color, show_boom, score, miss, round, game_over
  );
endinterface

// File: rtl/game_round_scheduler.sv
// Round sequencer for the 4x4 whack-target game: picks a pseudo-random lit cell,
// times it, judges key hits and keeps score/miss/round tallies until game end.
module game_round_scheduler #(
  parameter int unsigned SHOW_TICKS = 1_500_000,
  parameter int unsigned GAP_TICKS  = 200_000,
  parameter int unsigned ROUNDS     = 10,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input logic                    clk,
  input logic                    rst_n,
  game_round_scheduler_if.master bus
);

  localparam int unsigned MAX_TICKS = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS);
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [7:0]       ROUNDS_8  = 8'(ROUNDS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_SHOW = 3'd2,
    ST_BOOM = 3'd3,
    ST_MISS = 3'd4,
    ST_OVER = 3'd5
  } state_t;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; maximal length, so a non-zero seed never reaches 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  state_t           state_r;
  logic [7:0]       lfsr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       prev_pos_r;
  logic             disp_en_r;
  logic [3:0]       disp_pos_r;
  logic [1:0]       disp_color_r;
  logic             show_boom_r;
  logic [7:0]       score_r;
  logic [7:0]       miss_r;
  logic [7:0]       round_r;
  logic             game_over_r;

  logic [3:0]       target_pos_s;
  logic [1:0]       target_color_s;
  logic             cnt_zero_s;
  logic             last_round_s;
  logic [7:0]       next_round_s;

  assign cnt_zero_s   = (cnt_r == CNT_ZERO);
  assign next_round_s = round_r + 8'd1;
  assign last_round_s = (next_round_s == ROUNDS_8);

  // Next target cell and colour derived from the current LFSR state.
  always_comb begin
    target_pos_s   = lfsr_r[3:0];
    target_color_s = lfsr_r[5:4];
    if (lfsr_r[3:0] == prev_pos_r) begin
      target_pos_s = lfsr_r[3:0] + 4'd1;
    end else begin
      target_pos_s = lfsr_r[3:0];
    end
    if (lfsr_r[5:4] == 2'b00) begin
      target_color_s = 2'b01;
    end else begin
      target_color_s = lfsr_r[5:4];
    end
  end

  // Free-running pseudo-random source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Round state machine with all display and tally outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      prev_pos_r   <= 4'd0;
      disp_en_r    <= 1'b0;
      disp_pos_r   <= 4'd0;
      disp_color_r <= 2'b00;
      show_boom_r  <= 1'b0;
      score_r      <= 8'd0;
      miss_r       <= 8'd0;
      round_r      <= 8'd0;
      game_over_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_OVER: begin
          disp_en_r   <= 1'b0;
          show_boom_r <= 1'b0;
          if (bus.start) begin
            score_r     <= 8'd0;
            miss_r      <= 8'd0;
            round_r     <= 8'd0;
            game_over_r <= 1'b0;
            cnt_r       <= GAP_LOAD;
            state_r     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_zero_s) begin
            disp_pos_r   <= target_pos_s;
            prev_pos_r   <= target_pos_s;
            disp_color_r <= target_color_s;
            disp_en_r    <= 1'b1;
            cnt_r        <= SHOW_LOAD;
            state_r      <= ST_SHOW;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_SHOW: begin
          // A key on the expiry cycle still wins over the timeout.
          if (bus.key_valid && (bus.key_pos == disp_pos_r)) begin
            score_r     <= sat_inc(score_r);
            show_boom_r <= 1'b1;
            state_r     <= ST_BOOM;
          end else if (bus.key_valid || cnt_zero_s) begin
            disp_en_r <= 1'b0;
            state_r   <= ST_MISS;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_BOOM: begin
          if (bus.finish_boom) begin
            show_boom_r <= 1'b0;
            disp_en_r   <= 1'b0;
            round_r     <= next_round_s;
            if (last_round_s) begin
              game_over_r <= 1'b1;
              state_r     <= ST_OVER;
            end else begin
              cnt_r   <= GAP_LOAD;
              state_r <= ST_GAP;
            end
          end
        end
        ST_MISS: begin
          miss_r  <= sat_inc(miss_r);
          round_r <= next_round_s;
          if (last_round_s) begin
            game_over_r <= 1'b1;
            state_r     <= ST_OVER;
          end else begin
            cnt_r   <= GAP_LOAD;
            state_r <= ST_GAP;
          end
        end
        default: begin
          disp_en_r   <= 1'b0;
          show_boom_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.disp_en    = disp_en_r;
  assign bus.disp_pos   = disp_pos_r;
  assign bus.disp_color = disp_color_r;
  assign bus.show_boom  = show_boom_r;
  assign bus.score      = score_r;
  assign bus.miss       = miss_r;
  assign bus.round      = round_r;
  assign bus.game_over  = game_over_r;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Directed bench for game_round_scheduler with short timing parameters and an
// independent LFSR/target model used to predict every lit cell.
module tb_game_round_scheduler;

  localparam int SHOW = 20;
  localparam int GAP  = 5;
  localparam int NR   = 3;

  logic clk = 1'b0;
  logic rst_n;

  game_round_scheduler_if bus();

  game_round_scheduler #(
    .SHOW_TICKS(SHOW),
    .GAP_TICKS (GAP),
    .ROUNDS    (NR),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0] lfsr_m;
  logic [3:0] exp_prev;
  logic [3:0] cur_pos;
  logic [1:0] cur_color;
  logic [3:0] old_prev;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] adv(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = lfsr_next(r);
    return r;
  endfunction

  // Reference LFSR, advancing on every clock outside reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 8'hA5;
    else        lfsr_m <= lfsr_next(lfsr_m);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, 32'({bus.disp_en, bus.disp_pos, bus.disp_color, bus.show_boom, bus.game_over}), 32'd0);
    chk({tag, "_cnts"}, 32'({bus.score, bus.miss, bus.round}), 32'd0);
  endtask

  // Called at the negedge whose following posedge enters GAP; ends in SHOW.
  task automatic run_gap(input logic [7:0] l_entry);
    logic [7:0] v;
    logic [3:0] p;
    v = adv(l_entry, GAP);
    p = v[3:0];
    if (p == exp_prev) p = p + 4'd1;
    cur_pos   = p;
    exp_prev  = p;
    cur_color = (v[5:4] == 2'b00) ? 2'b01 : v[5:4];
    for (int k = 0; k < GAP; k++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.finish_boom = 1'b0; bus.key_valid = 1'b0;
      chk("gap_en", 32'(bus.disp_en), 32'd0);
      chk("gap_boom", 32'(bus.show_boom), 32'd0);
      chk("gap_over", 32'(bus.game_over), 32'd0);
    end
    @(negedge clk);
    chk("show_en", 32'(bus.disp_en), 32'd1);
    chk("show_pos", 32'(bus.disp_pos), 32'(cur_pos));
    chk("show_color", 32'(bus.disp_color), 32'(cur_color));
    chk("color_nz", 32'(bus.disp_color != 2'b00), 32'd1);
  endtask

  // Wait (bounded) until a GAP entered at the next edge would latch nibble 'want'.
  task automatic seek(input logic [3:0] want);
    logic [7:0] v;
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      v = adv(lfsr_m, GAP);
      if (v[3:0] == want) found = 1'b1;
      else @(negedge clk);
    end
    chk("seek_found", 32'(found), 32'd1);
  endtask

  task automatic press(input logic [3:0] pos);
    bus.key_valid = 1'b1;
    bus.key_pos   = pos;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_pos = 4'd0; bus.finish_boom = 1'b0;
    exp_prev = 4'd0; cur_pos = 4'd0; cur_color = 2'b00; old_prev = 4'd0;

    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_en", 32'(bus.disp_en), 32'd0);

    // Game 1, round 1: correct key, long explosion
    bus.start = 1'b1;
    run_gap(lfsr_m);
    chk("g1_cnts", 32'({bus.score, bus.miss, bus.round}), 32'd0);
    press(cur_pos);
    chk("hit_boom", 32'(bus.show_boom), 32'd1);
    chk("hit_score", 32'(bus.score), 32'd1);
    for (int i = 0; i < 30; i++) begin
      if (i == 10) begin bus.key_valid = 1'b1; bus.key_pos = cur_pos; end
      else bus.key_valid = 1'b0;
      @(negedge clk);
      chk("boom_hold", 32'(bus.show_boom), 32'd1);
      chk("boom_pos", 32'({bus.disp_pos, bus.disp_color}), 32'({cur_pos, cur_color}));
    end
    bus.key_valid = 1'b0;
    chk("boom_key_ign", 32'(bus.score), 32'd1);
    bus.finish_boom = 1'b1;
    run_gap(lfsr_m);
    chk("r1_cnts", 32'({bus.score, bus.miss, bus.round}), 32'h010001);

    // Round 2: wrong key
    press(cur_pos ^ 4'h5);
    chk("miss_en", 32'(bus.disp_en), 32'd0);
    chk("miss_boom", 32'(bus.show_boom), 32'd0);
    run_gap(lfsr_m);
    chk("r2_cnts", 32'({bus.score, bus.miss, bus.round}), 32'h010102);

    // Round 3: timeout after exactly SHOW cycles
    for (int j = 1; j < SHOW; j++) begin
      @(negedge clk);
      chk("to_wait", 32'({bus.disp_en, bus.miss}), 32'({1'b1, 8'd1}));
    end
    @(negedge clk);
    chk("to_expire", 32'({bus.disp_en, bus.miss}), 32'({1'b0, 8'd1}));
    @(negedge clk);
    chk("over_cnts", 32'({bus.score, bus.miss, bus.round}), 32'h010203);
    chk("over_flag", 32'(bus.game_over), 32'd1);

    // OVER ignores keys and holds tallies
    press(cur_pos);
    repeat (3) @(negedge clk);
    chk("over_hold", 32'({bus.score, bus.miss, bus.round}), 32'h010203);
    chk("over_flags", 32'({bus.game_over, bus.disp_en, bus.show_boom}), 32'h4);

    // Game 2, round 1: target collides with previous cell
    seek(exp_prev);
    old_prev = exp_prev;
    bus.start = 1'b1;
    run_gap(lfsr_m);
    chk("collide_pos", 32'(bus.disp_pos), 32'(old_prev + 4'd1));
    chk("g2_cnts", 32'({bus.score, bus.miss, bus.round, bus.game_over}), 32'd0);
    repeat (SHOW - 1) @(negedge clk);
    press(cur_pos);
    chk("late_hit", 32'({bus.show_boom, bus.score, bus.miss}), 32'h10100);

    // Rounds 2 and 3 steer the LFSR so one of them hits the 4'hF wrap
    seek(4'hF);
    bus.finish_boom = 1'b1;
    run_gap(lfsr_m);
    chk("g2r1_round", 32'(bus.round), 32'd1);
    press(cur_pos);
    chk("g2r2_hit", 32'({bus.show_boom, bus.score}), 32'h102);
    seek(4'hF);
    old_prev = exp_prev;
    bus.finish_boom = 1'b1;
    run_gap(lfsr_m);
    chk("wrap_pos", 32'(bus.disp_pos), 32'((old_prev == 4'hF) ? 4'h0 : 4'hF));
    press(cur_pos);
    chk("g2r3_hit", 32'({bus.show_boom, bus.score, bus.round}), 32'h10302);

    // Asynchronous reset in the middle of an explosion
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    chk_all_zero("rst_hold");
    rst_n = 1'b1;
    exp_prev = 4'd0;
    @(negedge clk);
    chk("post_rst_idle", 32'({bus.disp_en, bus.show_boom}), 32'd0);
    bus.start = 1'b1;
    run_gap(lfsr_m);
    press(cur_pos);
    chk("g3_hit", 32'({bus.show_boom, bus.score}), 32'h101);
    bus.finish_boom = 1'b1;
    @(negedge clk);
    bus.finish_boom = 1'b0;
    chk("g3_done", 32'({bus.show_boom, bus.disp_en, bus.round}), 32'h001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
